// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution input-stream sequencer.
// The tuser bit positions match the ones the engine already decodes.
package conv_seq_pkg;

  localparam int CS_BITS_KW2    = 2;
  localparam int CS_BITS_SW     = 2;
  localparam int CS_BITS_CIN    = 10;
  localparam int CS_BITS_COLS   = 10;
  localparam int CS_BITS_BLOCKS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CFG  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [CS_BITS_KW2-1:0]    kw2;
    logic [CS_BITS_SW-1:0]     sw_1;
    logic [CS_BITS_CIN-1:0]    cin_1;
    logic [CS_BITS_COLS-1:0]   cols_1;
    logic [CS_BITS_BLOCKS-1:0] blocks_1;
  } conv_cfg_t;

  localparam int I_IS_CONFIG       = 0;
  localparam int I_IS_CIN_LAST     = 1;
  localparam int I_IS_W_FIRST      = 2;
  localparam int I_IS_COL_VALID    = 3;
  localparam int I_IS_SUM_START    = 4;
  localparam int I_KW2             = 5;
  localparam int I_SW_1            = I_KW2 + CS_BITS_KW2;
  localparam int I_IS_BOTTOM_BLOCK = I_SW_1 + CS_BITS_SW;
  localparam int TUSER_W           = I_IS_BOTTOM_BLOCK + 1;

  // Last kernel tap index: KW-1 = 2*kw2.
  function automatic logic [CS_BITS_KW2:0] kernel_max(input logic [CS_BITS_KW2-1:0] kw2);
    return {kw2, 1'b0};
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter: counts 0..max on en and wraps; clr forces zero and wins over en.
module wrap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] max,
  output logic [W-1:0] count,
  output logic         at_max
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  assign count  = count_reg;
  assign at_max = (count_reg == max);

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = at_max ? '0 : count_reg + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/conv_user_sequencer.sv
// Stamps each accepted beat of the engine input stream with tuser flags and last,
// driven by nested kernel/channel/column/block counters loaded from a layer config.
module conv_user_sequencer
  import conv_seq_pkg::*;
#(
  parameter int BITS_KW2    = CS_BITS_KW2,
  parameter int BITS_SW     = CS_BITS_SW,
  parameter int BITS_CIN    = CS_BITS_CIN,
  parameter int BITS_COLS   = CS_BITS_COLS,
  parameter int BITS_BLOCKS = CS_BITS_BLOCKS
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clken,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [BITS_KW2-1:0]    cfg_kw2,
  input  logic [BITS_SW-1:0]     cfg_sw_1,
  input  logic [BITS_CIN-1:0]    cfg_cin_1,
  input  logic [BITS_COLS-1:0]   cfg_cols_1,
  input  logic [BITS_BLOCKS-1:0] cfg_blocks_1,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   m_is_config,
  output logic                   m_is_cin_last,
  output logic                   m_is_w_first,
  output logic                   m_is_col_valid,
  output logic                   m_is_sum_start,
  output logic                   m_is_bottom_block,
  output logic [BITS_KW2-1:0]    m_kw2,
  output logic [BITS_SW-1:0]     m_sw_1,
  output logic                   done
);

  seq_state_t state_reg, state_next;
  conv_cfg_t  cfg_reg;

  logic in_stream, acc, acc_run, load;
  logic step_cin, step_col, step_blk, all_max;

  logic [BITS_KW2:0]      k_count,   k_max;
  logic [BITS_CIN-1:0]    cin_count;
  logic [BITS_COLS-1:0]   col_count;
  logic [BITS_BLOCKS-1:0] blk_count;
  logic [BITS_SW-1:0]     ph_count;
  logic k_at_max, cin_at_max, col_at_max, blk_at_max, ph_at_max;

  logic [TUSER_W-1:0] user_vec;

  assign in_stream = (state_reg == CFG) || (state_reg == RUN);
  assign acc       = clken & s_valid & m_ready & in_stream;
  assign acc_run   = acc & (state_reg == RUN);
  assign load      = clken & cfg_valid & (state_reg == IDLE);

  assign step_cin = acc_run & k_at_max;
  assign step_col = step_cin & cin_at_max;
  assign step_blk = step_col & col_at_max;
  assign all_max  = k_at_max & cin_at_max & col_at_max & blk_at_max;
  assign k_max    = kernel_max(cfg_reg.kw2);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cfg_reg <= '0;
    end else if (load) begin
      cfg_reg.kw2      <= cfg_kw2;
      cfg_reg.sw_1     <= cfg_sw_1;
      cfg_reg.cin_1    <= cfg_cin_1;
      cfg_reg.cols_1   <= cfg_cols_1;
      cfg_reg.blocks_1 <= cfg_blocks_1;
    end
  end

  wrap_counter #(.W(BITS_KW2 + 1)) u_k_cnt (
    .clk(clk), .resetn(resetn), .en(acc_run), .clr(load),
    .max(k_max), .count(k_count), .at_max(k_at_max)
  );

  wrap_counter #(.W(BITS_CIN)) u_cin_cnt (
    .clk(clk), .resetn(resetn), .en(step_cin), .clr(load),
    .max(cfg_reg.cin_1), .count(cin_count), .at_max(cin_at_max)
  );

  wrap_counter #(.W(BITS_COLS)) u_col_cnt (
    .clk(clk), .resetn(resetn), .en(step_col), .clr(load),
    .max(cfg_reg.cols_1), .count(col_count), .at_max(col_at_max)
  );

  wrap_counter #(.W(BITS_BLOCKS)) u_blk_cnt (
    .clk(clk), .resetn(resetn), .en(step_blk), .clr(load),
    .max(cfg_reg.blocks_1), .count(blk_count), .at_max(blk_at_max)
  );

  // Stride phase advances once per column and restarts with every new row block.
  wrap_counter #(.W(BITS_SW)) u_ph_cnt (
    .clk(clk), .resetn(resetn), .en(step_col), .clr(load | step_blk),
    .max(cfg_reg.sw_1), .count(ph_count), .at_max(ph_at_max)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (load) state_next = CFG;
      CFG:  if (acc) state_next = RUN;
      RUN:  if (acc && all_max) state_next = DONE;
      DONE: if (clken) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    user_vec = '0;
    user_vec[I_KW2 +: CS_BITS_KW2] = cfg_reg.kw2;
    user_vec[I_SW_1 +: CS_BITS_SW] = cfg_reg.sw_1;
    m_last = 1'b0;
    case (state_reg)
      CFG: user_vec[I_IS_CONFIG] = 1'b1;
      RUN: begin
        user_vec[I_IS_CIN_LAST]     = (k_count == k_max) && (cin_count == cfg_reg.cin_1);
        user_vec[I_IS_W_FIRST]      = (col_count == '0);
        user_vec[I_IS_COL_VALID]    = (col_count >= BITS_COLS'(cfg_reg.kw2));
        user_vec[I_IS_SUM_START]    = (ph_count == '0) | (ph_at_max & (cfg_reg.sw_1 == '0));
        user_vec[I_IS_BOTTOM_BLOCK] = (blk_count == cfg_reg.blocks_1);
        m_last                      = all_max;
      end
      default: ;
    endcase
  end

  assign m_is_config       = user_vec[I_IS_CONFIG];
  assign m_is_cin_last     = user_vec[I_IS_CIN_LAST];
  assign m_is_w_first      = user_vec[I_IS_W_FIRST];
  assign m_is_col_valid    = user_vec[I_IS_COL_VALID];
  assign m_is_sum_start    = user_vec[I_IS_SUM_START];
  assign m_is_bottom_block = user_vec[I_IS_BOTTOM_BLOCK];
  assign m_kw2             = user_vec[I_KW2 +: BITS_KW2];
  assign m_sw_1            = user_vec[I_SW_1 +: BITS_SW];

  assign cfg_ready = (state_reg == IDLE);
  assign s_ready   = in_stream & m_ready;
  assign m_valid   = in_stream & s_valid;
  assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_conv_user_sequencer.sv
// Directed bench: per-layer expected beat tables compared beat by beat, plus
// stall, clock-enable freeze, mid-layer reset and config-during-run sequences.
module tb_conv_user_sequencer;

  logic       clk = 1'b0;
  logic       resetn, clken, cfg_valid, s_valid, m_ready;
  logic [1:0] cfg_kw2, cfg_sw_1;
  logic [9:0] cfg_cin_1, cfg_cols_1, cfg_blocks_1;
  logic       cfg_ready, s_ready, m_valid, m_last, done;
  logic       m_is_config, m_is_cin_last, m_is_w_first, m_is_col_valid;
  logic       m_is_sum_start, m_is_bottom_block;
  logic [1:0] m_kw2, m_sw_1;

  conv_user_sequencer dut (
    .clk(clk), .resetn(resetn), .clken(clken),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_kw2(cfg_kw2), .cfg_sw_1(cfg_sw_1), .cfg_cin_1(cfg_cin_1),
    .cfg_cols_1(cfg_cols_1), .cfg_blocks_1(cfg_blocks_1),
    .s_valid(s_valid), .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_is_config(m_is_config), .m_is_cin_last(m_is_cin_last),
    .m_is_w_first(m_is_w_first), .m_is_col_valid(m_is_col_valid),
    .m_is_sum_start(m_is_sum_start), .m_is_bottom_block(m_is_bottom_block),
    .m_kw2(m_kw2), .m_sw_1(m_sw_1), .done(done)
  );

  always #5 clk = ~clk;

  // One record per layer run; mode 0 plain, 1 m_ready stalls, 2 clken freeze, 3 cfg during run.
  typedef struct {
    int kw2; int sw_1; int cin_1; int cols_1; int blocks_1; int mode; int ev;
  } case_t;

  case_t      cases [6];
  logic [6:0] exp_tbl [64];
  int         exp_n;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cur_kw2, cur_sw_1;
  logic [3:0] stall_pat = 4'b1001;

  function automatic logic [6:0] flags();
    return {m_is_config, m_is_cin_last, m_is_w_first, m_is_col_valid,
            m_is_sum_start, m_is_bottom_block, m_last};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Expected beats: {config, cin_last, w_first, col_valid, sum_start, bottom, last}.
  task automatic build_exp(input int kw2, input int sw_1, input int cin_1,
                           input int cols_1, input int blocks_1);
    int idx;
    idx = 1;
    exp_tbl[0] = 7'b1000000;
    for (int b = 0; b <= blocks_1; b++)
      for (int c = 0; c <= cols_1; c++)
        for (int ci = 0; ci <= cin_1; ci++)
          for (int k = 0; k <= 2 * kw2; k++) begin
            exp_tbl[idx] = {1'b0,
                            (k == 2 * kw2) && (ci == cin_1),
                            c == 0,
                            c >= kw2,
                            (c % (sw_1 + 1)) == 0,
                            b == blocks_1,
                            (k == 2 * kw2) && (ci == cin_1) && (c == cols_1) && (b == blocks_1)};
            idx++;
          end
    exp_n = idx;
  endtask

  task automatic load_cfg(input int kw2, input int sw_1, input int cin_1,
                          input int cols_1, input int blocks_1);
    @(negedge clk);
    #1;
    chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_kw2 = 2'(kw2); cfg_sw_1 = 2'(sw_1); cfg_cin_1 = 10'(cin_1);
    cfg_cols_1 = 10'(cols_1); cfg_blocks_1 = 10'(blocks_1);
    cur_kw2 = kw2; cur_sw_1 = sw_1;
    @(negedge clk);
    cfg_valid = 1'b0;
    #1;
    chk("m_kw2_latched", 32'(m_kw2), 32'(kw2));
    chk("m_sw_1_latched", 32'(m_sw_1), 32'(sw_1));
    chk("cfg_ready_cfg", 32'(cfg_ready), 32'd0);
    build_exp(kw2, sw_1, cin_1, cols_1, blocks_1);
  endtask

  task automatic stream(input int n, input int mode, input int ev, input bit expect_done);
    int idx, cyc;
    bit froze;
    idx = 0; cyc = 0; froze = 0;
    while (idx < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      s_valid = 1'b1;
      clken   = 1'b1;
      m_ready = (mode == 1) ? stall_pat[cyc % 4] : 1'b1;
      if (mode == 3) begin
        cfg_valid = 1'b1; cfg_kw2 = 2'd3; cfg_sw_1 = 2'd2;
        cfg_cin_1 = 10'd7; cfg_cols_1 = 10'd9; cfg_blocks_1 = 10'd4;
      end
      if (mode == 2 && idx == ev && !froze) begin
        froze = 1;
        clken = 1'b0;
        for (int f = 0; f < 5; f++) begin
          #1;
          chk($sformatf("freeze_flags_%0d", f), 32'(flags()), 32'(exp_tbl[idx]));
          chk($sformatf("freeze_done_%0d", f), 32'(done), 32'd0);
          @(negedge clk);
        end
        clken = 1'b1;
      end
      #1;
      if (mode == 3) begin
        chk("cfg_ready_run", 32'(cfg_ready), 32'd0);
        chk("m_kw2_run", 32'(m_kw2), 32'(cur_kw2));
      end
      chk("s_ready_follow", 32'(s_ready), 32'(m_ready));
      if (m_valid && m_ready) begin
        chk($sformatf("beat_%0d", idx), 32'(flags()), 32'(exp_tbl[idx]));
        $display("beat %0d flags %b", idx, flags());
        idx++;
      end else if (m_valid) begin
        chk($sformatf("stall_beat_%0d", idx), 32'(flags()), 32'(exp_tbl[idx]));
      end
    end
    if (idx < n) chk("stream_timeout", 32'(idx), 32'(n));
    if (expect_done) begin
      @(negedge clk);
      s_valid = 1'b0; cfg_valid = 1'b0; m_ready = 1'b1;
      #1;
      chk("done_pulse", 32'(done), 32'd1);
      chk("m_valid_done", 32'(m_valid), 32'd0);
      chk("m_last_done", 32'(m_last), 32'd0);
      @(negedge clk);
      #1;
      chk("done_cleared", 32'(done), 32'd0);
      chk("cfg_ready_back", 32'(cfg_ready), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_flags"}, 32'(flags()), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_m_kw2"}, 32'(m_kw2), 32'd0);
    chk({tag, "_m_sw_1"}, 32'(m_sw_1), 32'd0);
  endtask

  initial begin
    cases[0] = '{1, 0, 1, 2, 0, 0, 0};
    cases[1] = '{0, 1, 0, 3, 0, 0, 0};
    cases[2] = '{1, 0, 1, 2, 0, 1, 0};
    cases[3] = '{1, 0, 1, 2, 0, 2, 9};
    cases[4] = '{0, 0, 0, 0, 1, 3, 0};
    cases[5] = '{3, 2, 0, 1, 1, 0, 0};

    resetn = 1'b0; clken = 1'b1; cfg_valid = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    cfg_kw2 = '0; cfg_sw_1 = '0; cfg_cin_1 = '0; cfg_cols_1 = '0; cfg_blocks_1 = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    resetn = 1'b1;
    s_valid = 1'b0;

    for (int i = 0; i < 6; i++) begin
      load_cfg(cases[i].kw2, cases[i].sw_1, cases[i].cin_1, cases[i].cols_1, cases[i].blocks_1);
      $display("case %0d: kw2=%0d sw_1=%0d cin_1=%0d cols_1=%0d blocks_1=%0d mode=%0d beats=%0d",
               i, cases[i].kw2, cases[i].sw_1, cases[i].cin_1, cases[i].cols_1,
               cases[i].blocks_1, cases[i].mode, exp_n);
      stream(exp_n, cases[i].mode, cases[i].ev, 1'b1);
    end

    // Reset while RUN beat 9 is being presented, then a fresh layer from scratch.
    load_cfg(1, 0, 1, 2, 0);
    stream(9, 0, 0, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("midreset");
    $display("mid-layer reset applied at run beat 9");
    resetn = 1'b1;
    s_valid = 1'b0;
    load_cfg(1, 0, 1, 2, 0);
    chk("restart_config_beat", 32'(flags()), 32'h40);
    stream(exp_n, 0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
